mkmif_spi_engine: RTL and testbench
===================================

MKMIF_SPI_ENGINE -- requirements
Module: mkmif_spi_engine

Interface
REQ-001 SHALL have parameter: none; all widths fixed.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 spi_sclk  output  1  SPI clock to 23K640, mode 0 (idle low).
REQ-005 spi_cs_n  output  1  SPI chip select, active-low.
REQ-006 spi_do  input  1  serial data from memory SO pin.
REQ-007 spi_di  output  1  serial data to memory SI pin.
REQ-008 enable  input  1  frame control; 1 = hold chip select asserted.
REQ-009 set  input  1  load wr_data into transmit shift register.
REQ-010 start  input  1  one-cycle pulse, begin transfer.
REQ-011 length  input  3  transfer size; bytes = length+1 (1..8).
REQ-012 divisor  input  16  SCLK half-period in clk cycles; 0 treated as 1.
REQ-013 ready  output  1  1 = idle, accepts set/start.
REQ-014 wr_data  input  64  transmit data, MSB sent first.
REQ-015 rd_data  output  32  last 32 bits sampled from spi_do, newest bit in [0].

Function
REQ-016 SHALL implement FSM states IDLE, SCLK_LOW, SCLK_HIGH, encoded as local constants.
REQ-017 spi_cs_n SHALL be a register loaded with ~enable every cycle (one-cycle latency).
REQ-018 In IDLE with set=1, tx_reg SHALL load wr_data; set outside IDLE SHALL be ignored.
REQ-019 In IDLE with start=1 and enable=1, SHALL enter SCLK_LOW, clear ready, clear divider counter, load bit counter with 8*(length+1).
REQ-020 Simultaneous set and start in IDLE SHALL load wr_data and start the transfer with the newly loaded data.
REQ-021 start with enable=0, or start when not IDLE, SHALL be ignored (no state change).
REQ-022 spi_di SHALL equal tx_reg[63] at all times.
REQ-023 Divider counter SHALL count 0..D-1 (D = max(divisor,1)); each phase lasts exactly D cycles.
REQ-024 At end of SCLK_LOW: spi_sclk<=1, rx_reg<={rx_reg[30:0],spi_do}, go SCLK_HIGH.
REQ-025 At end of SCLK_HIGH: spi_sclk<=0, tx_reg shifts left one bit (zero fill), bit counter decrements; if it reaches 0 go IDLE and set ready, else go SCLK_LOW.
REQ-026 ready SHALL be low for exactly 2*D*8*(length+1) cycles per transfer.
REQ-027 enable deasserted while not IDLE SHALL abort: next cycle state IDLE, spi_sclk 0, ready 1; rx_reg keeps partial contents.
REQ-028 rd_data SHALL be rx_reg directly; not cleared by start.
REQ-029 divisor and length SHALL be sampled only at start; changes mid-transfer SHALL have no effect.

Reset
REQ-030 On reset_n low: state IDLE, spi_sclk 0, spi_cs_n 1, ready 1, tx_reg 0 (spi_di 0), rx_reg 0 (rd_data 0), counters 0.
REQ-031 Reset asserted mid-transfer SHALL take effect immediately without completing the byte.

Structure
REQ-032 SPI opcodes (READ 8'h03, WRITE 8'h02, RDSR 8'h05, WRSR 8'h01) and status value 8'b01000001 SHALL live in shared package mkmif_pkg used by mkmif_core and this block.
REQ-033 FSM encodings SHALL remain local; no sub-module, divider counter inlined.

Verification
REQ-034 Reset: after reset_n release, sclk=0, cs_n=1, ready=1, di=0, rd_data=0.
REQ-035 divisor=2, length=0, set with wr_data=64'hA5<<56, enable=1, start -> di at 8 rising sclk edges = 1,0,1,0,0,1,0,1; ready low 32 cycles.
REQ-036 Read frame: length=6, wr_data={8'h03,16'h0010,40'h0}, memory model drives 32'hDEADBEEF in bytes 4-7 -> rd_data=32'hDEADBEEF, 56 sclk pulses.
REQ-037 divisor=0, length=0 -> behaves as D=1: sclk toggles every cycle, ready low 16 cycles.
REQ-038 Abort: enable dropped 10 cycles into transfer -> cs_n=1 and ready=1 one cycle later, sclk=0, state IDLE.
REQ-039 start with enable=0 -> ready stays 1, no sclk edges; second start while busy -> ignored, pulse count unchanged.

Source files
------------

// File: rtl/mkmif_pkg.sv
// Shared definitions for the 23K640 SPI SRAM interface: opcodes, expected
// status register value and frame-size helper.
package mkmif_pkg;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;
  localparam logic [7:0] SPI_OP_RDSR  = 8'h05;
  localparam logic [7:0] SPI_OP_WRSR  = 8'h01;
  localparam logic [7:0] SPI_STATUS   = 8'b01000001;

  // Number of bits in a frame of length+1 bytes (8..64).
  function automatic logic [6:0] xfer_bits(input logic [2:0] length);
    logic [3:0] bytes_s;
    bytes_s = {1'b0, length} + 4'd1;
    return {bytes_s, 3'b000};
  endfunction

endpackage

// File: rtl/mkmif_spi_engine_if.sv
// Host-side control/data bus of the SPI engine.
interface mkmif_spi_engine_if;
  logic        enable;
  logic        set;
  logic        start;
  logic [2:0]  length;
  logic [15:0] divisor;
  logic        ready;
  logic [63:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output enable, set, start, length, divisor, wr_data,
    input  ready, rd_data
  );

  modport slave (
    input  enable, set, start, length, divisor, wr_data,
    output ready, rd_data
  );
endinterface

// File: rtl/mkmif_spi_engine.sv
// Mode-0 SPI bit engine for the 23K640: shifts out up to 64 bits MSB first
// while sampling SO into a 32-bit receive register.
module mkmif_spi_engine
  import mkmif_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  output logic spi_sclk,
  output logic spi_cs_n,
  input  logic spi_do,
  output logic spi_di,
  mkmif_spi_engine_if.slave ctrl
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCLK_LOW  = 2'd1,
    SCLK_HIGH = 2'd2
  } state_t;

  state_t      state_r, state_nxt;
  logic        sclk_r, sclk_nxt;
  logic        cs_n_r;
  logic        ready_r, ready_nxt;
  logic [63:0] tx_reg_r, tx_nxt;
  logic [31:0] rx_reg_r, rx_nxt;
  logic [15:0] div_cnt_r, div_cnt_nxt;
  logic [15:0] div_max_r, div_max_nxt;
  logic [6:0]  bit_cnt_r, bit_cnt_nxt;
  logic        phase_end_s;

  assign spi_sclk     = sclk_r;
  assign spi_cs_n     = cs_n_r;
  assign spi_di       = tx_reg_r[63];
  assign ctrl.ready   = ready_r;
  assign ctrl.rd_data = rx_reg_r;

  // State and datapath registers; reset acts immediately, even mid-byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      ready_r   <= 1'b1;
      tx_reg_r  <= 64'd0;
      rx_reg_r  <= 32'd0;
      div_cnt_r <= 16'd0;
      div_max_r <= 16'd0;
      bit_cnt_r <= 7'd0;
    end else begin
      state_r   <= state_nxt;
      sclk_r    <= sclk_nxt;
      cs_n_r    <= ~ctrl.enable;
      ready_r   <= ready_nxt;
      tx_reg_r  <= tx_nxt;
      rx_reg_r  <= rx_nxt;
      div_cnt_r <= div_cnt_nxt;
      div_max_r <= div_max_nxt;
      bit_cnt_r <= bit_cnt_nxt;
    end
  end

  // div_max holds D-1, so each phase spans exactly D clocks.
  assign phase_end_s = (div_cnt_r == div_max_r);

  // Next-state logic; dropping enable while busy aborts straight to IDLE.
  always_comb begin
    state_nxt   = state_r;
    sclk_nxt    = sclk_r;
    ready_nxt   = ready_r;
    tx_nxt      = tx_reg_r;
    rx_nxt      = rx_reg_r;
    div_cnt_nxt = div_cnt_r;
    div_max_nxt = div_max_r;
    bit_cnt_nxt = bit_cnt_r;

    case (state_r)
      IDLE: begin
        if (ctrl.set) begin
          tx_nxt = ctrl.wr_data;
        end else begin
          tx_nxt = tx_reg_r;
        end
        if (ctrl.start && ctrl.enable) begin
          state_nxt   = SCLK_LOW;
          ready_nxt   = 1'b0;
          div_cnt_nxt = 16'd0;
          bit_cnt_nxt = xfer_bits(ctrl.length);
          div_max_nxt = (ctrl.divisor == 16'd0) ? 16'd0 : ctrl.divisor - 16'd1;
        end else begin
          state_nxt = IDLE;
        end
      end

      SCLK_LOW: begin
        if (!ctrl.enable) begin
          state_nxt   = IDLE;
          sclk_nxt    = 1'b0;
          ready_nxt   = 1'b1;
          div_cnt_nxt = 16'd0;
          bit_cnt_nxt = 7'd0;
        end else if (phase_end_s) begin
          state_nxt   = SCLK_HIGH;
          sclk_nxt    = 1'b1;
          rx_nxt      = {rx_reg_r[30:0], spi_do};
          div_cnt_nxt = 16'd0;
        end else begin
          div_cnt_nxt = div_cnt_r + 16'd1;
        end
      end

      SCLK_HIGH: begin
        if (!ctrl.enable) begin
          state_nxt   = IDLE;
          sclk_nxt    = 1'b0;
          ready_nxt   = 1'b1;
          div_cnt_nxt = 16'd0;
          bit_cnt_nxt = 7'd0;
        end else if (phase_end_s) begin
          sclk_nxt    = 1'b0;
          tx_nxt      = {tx_reg_r[62:0], 1'b0};
          bit_cnt_nxt = bit_cnt_r - 7'd1;
          div_cnt_nxt = 16'd0;
          if (bit_cnt_r == 7'd1) begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = SCLK_LOW;
          end
        end else begin
          div_cnt_nxt = div_cnt_r + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        sclk_nxt  = 1'b0;
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mkmif_spi_engine.sv
// Directed bench for mkmif_spi_engine with a 23K640-style SO model and a
// scoreboard of expected SI bits and read data.
module tb_mkmif_spi_engine;
  import mkmif_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic spi_sclk, spi_cs_n, spi_do, spi_di;

  mkmif_spi_engine_if bus ();

  mkmif_spi_engine dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_do   (spi_do),
    .spi_di   (spi_di),
    .ctrl     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic exp_di_q[$];
  logic [31:0] exp_rd_q[$];
  logic [3:0] sclk_hist;

  localparam logic [31:0] MEM_WORD = 32'hDEADBEEF;
  int mem_bit;
  logic [63:0] si_cap;
  logic [4:0] mem_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: counts SCLK rises in a frame, presents read data on bits 24..55.
  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) mem_bit <= 0;
    else begin
      mem_bit <= mem_bit + 1;
      si_cap  <= {si_cap[62:0], spi_di};
    end
  end

  always_comb begin
    mem_idx = 5'(55 - mem_bit);
    if (mem_bit >= 24 && mem_bit < 56) spi_do = MEM_WORD[mem_idx];
    else spi_do = 1'b0;
  end

  // Scoreboard: every SCLK rise must consume one expected SI bit.
  always @(posedge spi_sclk) begin
    #1;
    pulse_cnt <= pulse_cnt + 1;
    check("sclk_has_expectation", 64'(exp_di_q.size() > 0), 64'd1);
    if (exp_di_q.size() > 0) check("di_at_sclk_rise", 64'(spi_di), 64'(exp_di_q.pop_front()));
  end

  task automatic frame_open();
    bus.enable = 1'b0;
    @(negedge clk); @(negedge clk);
    check("cs_n_idle", 64'(spi_cs_n), 64'd1);
    bus.enable = 1'b1;
    @(negedge clk);
    check("cs_n_asserted", 64'(spi_cs_n), 64'd0);
  endtask

  task automatic push_bits(input logic [2:0] len, input logic [63:0] data);
    for (int i = 0; i < 8 * (int'(len) + 1); i++) exp_di_q.push_back(data[63 - i]);
  endtask

  task automatic run_xfer(input logic [2:0] len, input logic [15:0] div, input logic [63:0] data,
                          input bit busy_restart, input string tag);
    int cnt, p0, d, nbits;
    d = (div == 16'd0) ? 1 : int'(div);
    nbits = 8 * (int'(len) + 1);
    frame_open();
    push_bits(len, data);
    p0 = pulse_cnt;
    bus.length = len; bus.divisor = div; bus.wr_data = data;
    bus.set = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.set = 1'b0; bus.start = 1'b0;
    bus.length = ~len; bus.divisor = div + 16'd7;
    cnt = 0; sclk_hist = 4'd0;
    while (bus.ready === 1'b0 && cnt < 20000) begin
      if (cnt < 4) sclk_hist = {sclk_hist[2:0], spi_sclk};
      cnt++;
      @(negedge clk);
      if (busy_restart && cnt == 5) begin
        bus.start = 1'b1; bus.set = 1'b1; bus.wr_data = ~data;
      end else if (busy_restart && cnt == 6) begin
        bus.start = 1'b0; bus.set = 1'b0;
      end
    end
    check({tag, "_ready_low_cycles"}, 64'(cnt), 64'(2 * d * nbits));
    @(negedge clk);
    check({tag, "_sclk_pulses"}, 64'(pulse_cnt - p0), 64'(nbits));
    check({tag, "_di_queue_drained"}, 64'(exp_di_q.size()), 64'd0);
    check({tag, "_sclk_idle_low"}, 64'(spi_sclk), 64'd0);
  endtask

  initial begin
    int p0, ready_min;
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.set = 1'b0; bus.start = 1'b0;
    bus.length = 3'd0; bus.divisor = 16'd0; bus.wr_data = 64'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_sclk", 64'(spi_sclk), 64'd0);
    check("rst_cs_n", 64'(spi_cs_n), 64'd1);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_di", 64'(spi_di), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);

    run_xfer(3'd0, 16'd2, 64'hA500_0000_0000_0000, 1'b0, "byte_a5");

    exp_rd_q.push_back(32'hDEADBEEF);
    run_xfer(3'd6, 16'd2, {SPI_OP_READ, 16'h0010, 40'h0}, 1'b0, "read_frame");
    check("read_rd_data", 64'(bus.rd_data), 64'(exp_rd_q.pop_front()));
    check("read_cmd_on_si", 64'(si_cap[55:32]), 64'h030010);

    run_xfer(3'd0, 16'd0, 64'h3C00_0000_0000_0000, 1'b0, "div_zero");
    check("div_zero_sclk_each_cycle", 64'(sclk_hist), 64'b0101);

    run_xfer(3'd7, 16'd3, 64'h0123_4567_89AB_CDEF, 1'b0, "len8_div3");

    run_xfer(3'd0, 16'd2, 64'hC300_0000_0000_0000, 1'b1, "busy_restart");

    // Abort: enable dropped ten cycles into a long transfer.
    frame_open();
    push_bits(3'd7, 64'hF0F0_F0F0_F0F0_F0F0);
    bus.length = 3'd7; bus.divisor = 16'd2; bus.wr_data = 64'hF0F0_F0F0_F0F0_F0F0;
    bus.set = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.set = 1'b0; bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(bus.ready), 64'd0);
    bus.enable = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 64'(spi_cs_n), 64'd1);
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_sclk", 64'(spi_sclk), 64'd0);
    exp_di_q.delete();
    p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("abort_no_more_pulses", 64'(pulse_cnt - p0), 64'd0);

    // start without enable must be ignored.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ready_min = 1;
    repeat (8) begin
      if (bus.ready !== 1'b1) ready_min = 0;
      @(negedge clk);
    end
    check("start_no_enable_ready", 64'(ready_min), 64'd1);
    check("start_no_enable_pulses", 64'(pulse_cnt - p0), 64'd0);

    // Reset in the middle of a transfer.
    frame_open();
    push_bits(3'd3, 64'hFFFF_FFFF_0000_0000);
    bus.length = 3'd3; bus.divisor = 16'd4; bus.wr_data = 64'hFFFF_FFFF_0000_0000;
    bus.set = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.set = 1'b0; bus.start = 1'b0;
    repeat (22) @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_di_q.delete();
    check("midrst_sclk", 64'(spi_sclk), 64'd0);
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_cs_n", 64'(spi_cs_n), 64'd1);
    check("midrst_di", 64'(spi_di), 64'd0);
    check("midrst_rd_data", 64'(bus.rd_data), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_xfer(3'd1, 16'd1, 64'h5AA5_0000_0000_0000, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
